ym3438_lfo_ctrl: RTL and testbench

Register front end and slot sequencer for the LFO/phase-modulation datapath. It accepts CPU register writes over a request/acknowledge handshake and holds the LFO-related state: LFO enable/rate (0x22), test register (0x21), per-channel PMS (0xB4–0xB6) and F-number (0xA0–0xA6). A 24-slot counter walks the channels and presents the current slot's `pms`, `fnum`, `lfo`, `reg_21` and `fsm_sel23` to the LFO block each slot.

---
 rtl/ym3438_lfo_ctrl_pkg.sv | 44 ++++
 rtl/ym3438_lfo_ctrl_if.sv | 12 +
 rtl/ym3438_slot_counter.sv | 32 +++
 rtl/ym3438_lfo_ctrl.sv | 97 +++++++++
 tb/tb_ym3438_lfo_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/ym3438_lfo_ctrl_pkg.sv
// Shared constants, register decode and slot-to-channel helpers for the
// LFO register front end.
package ym3438_lfo_ctrl_pkg;

    localparam int unsigned SLOTS  = 24;
    localparam int unsigned NUM_CH = 6;
    localparam int unsigned CH_W   = 3;

    localparam logic [7:0] ADDR_TEST    = 8'h21;
    localparam logic [7:0] ADDR_LFO     = 8'h22;
    localparam logic [7:0] ADDR_FNUM_LO = 8'hA0;
    localparam logic [7:0] ADDR_FNUM_HI = 8'hA4;
    localparam logic [7:0] ADDR_PMS     = 8'hB4;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_TEST,
        REG_LFO,
        REG_PMS,
        REG_FNUM_HI,
        REG_FNUM_LO
    } reg_kind_e;

    // Global registers exist only in part 0; per-channel groups accept n = 0..2.
    function automatic reg_kind_e decode_addr(input logic [7:0] a, input logic part);
        reg_kind_e k;
        k = REG_NONE;
        if (!part && a == ADDR_TEST) begin
            k = REG_TEST;
        end else if (!part && a == ADDR_LFO) begin
            k = REG_LFO;
        end else if (a[1:0] != 2'd3) begin
            if (a[7:2] == ADDR_PMS[7:2])          k = REG_PMS;
            else if (a[7:2] == ADDR_FNUM_HI[7:2]) k = REG_FNUM_HI;
            else if (a[7:2] == ADDR_FNUM_LO[7:2]) k = REG_FNUM_LO;
        end
        return k;
    endfunction

    function automatic logic [CH_W-1:0] slot_to_ch(input logic [4:0] s);
        return CH_W'(s % 5'd6);
    endfunction

endpackage

// File: rtl/ym3438_lfo_ctrl_if.sv
// CPU register write bus: request held until a one-cycle acknowledge.
interface ym3438_lfo_ctrl_if;

    logic       wr_req;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;

    modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
    modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);

endinterface

// File: rtl/ym3438_slot_counter.sv
// Slot counter stepping on c1 ticks with wrap at SLOTS-1 and a registered
// last-slot flag; slot_next is exposed so users can prefetch per-slot data.
module ym3438_slot_counter #(
    parameter int unsigned SLOTS = 24
) (
    input  logic       MCLK,
    input  logic       reset,
    input  logic       c1,
    output logic [4:0] slot,
    output logic [4:0] slot_next,
    output logic       fsm_sel23
);

    localparam logic [4:0] LAST = 5'(SLOTS - 1);

    // Next slot value with wrap.
    always_comb begin
        slot_next = (slot == LAST) ? '0 : slot + 5'd1;
    end

    // Advance the slot and last-slot flag together on each tick.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            slot      <= '0;
            fsm_sel23 <= 1'b0;
        end else if (c1) begin
            slot      <= slot_next;
            fsm_sel23 <= (slot_next == LAST);
        end
    end

endmodule

// File: rtl/ym3438_lfo_ctrl.sv
// LFO register front end: write decode, per-channel PMS/F-number storage and
// slot-indexed presentation to the LFO datapath.
module ym3438_lfo_ctrl
    import ym3438_lfo_ctrl_pkg::*;
#(
    parameter int unsigned SLOTS = ym3438_lfo_ctrl_pkg::SLOTS
) (
    input  logic                    MCLK,
    input  logic                    reset,
    input  logic                    c1,
    ym3438_lfo_ctrl_if.slave        wr,
    output logic [3:0]              lfo,
    output logic [7:0]              reg_21,
    output logic                    fsm_sel23,
    output logic [4:0]              slot,
    output logic [2:0]              pms,
    output logic [10:0]             fnum
);

    logic            ack_q;
    logic            commit;
    reg_kind_e       kind;
    logic [CH_W-1:0] wch;
    logic [CH_W-1:0] nch;
    logic [4:0]      slot_next;
    logic [2:0]      pms_r  [NUM_CH];
    logic [10:0]     fnum_r [NUM_CH];
    logic [2:0]      fnum_hi;
    logic [2:0]      pms_nx;
    logic [10:0]     fnum_nx;

    assign wr.wr_ack = ack_q;

    ym3438_slot_counter #(.SLOTS(SLOTS)) u_slot (
        .MCLK      (MCLK),
        .reset     (reset),
        .c1        (c1),
        .slot      (slot),
        .slot_next (slot_next),
        .fsm_sel23 (fsm_sel23)
    );

    // Write decode and next-slot channel data; a write landing on the channel
    // that becomes current on this tick bypasses the stale stored value.
    always_comb begin
        commit  = c1 && wr.wr_req && !ack_q;
        kind    = decode_addr(wr.wr_addr[7:0], wr.wr_addr[8]);
        wch     = CH_W'({1'b0, wr.wr_addr[1:0]}) + (wr.wr_addr[8] ? CH_W'(3) : CH_W'(0));
        nch     = slot_to_ch(slot_next);
        pms_nx  = pms_r[nch];
        fnum_nx = fnum_r[nch];
        if (commit && kind == REG_PMS && wch == nch) begin
            pms_nx = wr.wr_data[5:3];
        end
        if (commit && kind == REG_FNUM_LO && wch == nch) begin
            fnum_nx = {fnum_hi, wr.wr_data};
        end
    end

    // Register file updates on a committed write.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            lfo     <= '0;
            reg_21  <= '0;
            fnum_hi <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                pms_r[i]  <= '0;
                fnum_r[i] <= '0;
            end
        end else if (commit) begin
            case (kind)
                REG_TEST:    reg_21      <= wr.wr_data;
                REG_LFO:     lfo         <= wr.wr_data[3:0];
                REG_PMS:     pms_r[wch]  <= wr.wr_data[5:3];
                REG_FNUM_HI: fnum_hi     <= wr.wr_data[2:0];
                REG_FNUM_LO: fnum_r[wch] <= {fnum_hi, wr.wr_data};
                default:     ;
            endcase
        end
    end

    // Acknowledge pulse and slot-indexed channel outputs.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            ack_q <= 1'b0;
            pms   <= '0;
            fnum  <= '0;
        end else begin
            ack_q <= commit;
            if (c1) begin
                pms  <= pms_nx;
                fnum <= fnum_nx;
            end
        end
    end

endmodule

// File: tb/tb_ym3438_lfo_ctrl.sv
// Directed self-checking bench for ym3438_lfo_ctrl.
module tb_ym3438_lfo_ctrl;

    logic        MCLK;
    logic        reset;
    logic        c1;
    logic [3:0]  lfo;
    logic [7:0]  reg_21;
    logic        fsm_sel23;
    logic [4:0]  slot;
    logic [2:0]  pms;
    logic [10:0] fnum;

    ym3438_lfo_ctrl_if bus ();

    ym3438_lfo_ctrl #(.SLOTS(24)) dut (
        .MCLK      (MCLK),
        .reset     (reset),
        .c1        (c1),
        .wr        (bus.slave),
        .lfo       (lfo),
        .reg_21    (reg_21),
        .fsm_sel23 (fsm_sel23),
        .slot      (slot),
        .pms       (pms),
        .fnum      (fnum)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned exp_slot = 0;
    logic [2:0]  exp_pms  [6];
    logic [10:0] exp_fnum [6];
    logic [3:0]  exp_lfo = '0;
    logic [7:0]  exp_r21 = '0;

    initial begin
        MCLK = 1'b0;
        forever #5 MCLK = ~MCLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one MCLK edge, track the expected slot, sample 1 ns later.
    task automatic tick();
        @(posedge MCLK);
        if (!reset && c1) exp_slot = (exp_slot == 23) ? 0 : exp_slot + 1;
        #1;
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("slot", slot, exp_slot);
            check("sel23", fsm_sel23, exp_slot == 23);
            check("pms", pms, exp_pms[exp_slot % 6]);
            check("fnum", fnum, exp_fnum[exp_slot % 6]);
        end
    endtask

    task automatic do_write(input logic part, input logic [7:0] a, input logic [7:0] d);
        logic got;
        @(negedge MCLK);
        bus.wr_req  = 1'b1;
        bus.wr_addr = {part, a};
        bus.wr_data = d;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (bus.wr_ack) got = 1'b1;
        end
        check("ack_seen", got, 1);
        check("lfo_at_ack", lfo, exp_lfo);
        check("r21_at_ack", reg_21, exp_r21);
        bus.wr_req = 1'b0;
        tick();
        check("ack_single", bus.wr_ack, 0);
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 6; i++) begin
            exp_pms[i]  = '0;
            exp_fnum[i] = '0;
        end
        reset       = 1'b1;
        c1          = 1'b1;
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        // Reset held three cycles.
        repeat (3) begin
            tick();
            check("rst_slot", slot, 0);
            check("rst_sel23", fsm_sel23, 0);
            check("rst_ack", bus.wr_ack, 0);
            check("rst_lfo", lfo, 0);
            check("rst_r21", reg_21, 0);
            check("rst_pms", pms, 0);
            check("rst_fnum", fnum, 0);
        end
        @(negedge MCLK);
        reset = 1'b0;
        sweep(25);
        check("idle_lfo", lfo, 0);
        check("idle_r21", reg_21, 0);

        // LFO and test registers; part-1 copies are discarded.
        exp_lfo = 4'hB;
        do_write(1'b0, 8'h22, 8'h0B);
        do_write(1'b1, 8'h22, 8'h05);
        exp_r21 = 8'h5A;
        do_write(1'b0, 8'h21, 8'h5A);
        do_write(1'b1, 8'h21, 8'hC3);

        // F-number for ch4 through part 1.
        do_write(1'b1, 8'hA5, 8'h03);
        do_write(1'b1, 8'hA1, 8'h45);
        exp_fnum[4] = 11'h345;
        sweep(24);

        // Shared high latch: written from part 0, consumed by part 1 and reused.
        do_write(1'b0, 8'hA4, 8'h02);
        do_write(1'b1, 8'hA2, 8'h10);
        exp_fnum[5] = 11'h210;
        do_write(1'b0, 8'hA0, 8'h77);
        exp_fnum[0] = 11'h277;

        // PMS ch2, then n=3 addresses that must change nothing.
        do_write(1'b0, 8'hB6, 8'h38);
        exp_pms[2] = 3'd7;
        do_write(1'b0, 8'hB7, 8'hFF);
        do_write(1'b1, 8'hA3, 8'hFF);
        sweep(24);

        // Write pending with c1 low: nothing moves until the tick returns.
        @(negedge MCLK);
        c1          = 1'b0;
        bus.wr_req  = 1'b1;
        bus.wr_addr = {1'b0, 8'hB4};
        bus.wr_data = 8'h28;
        repeat (5) begin
            tick();
            check("hold_ack", bus.wr_ack, 0);
            check("hold_slot", slot, exp_slot);
        end
        @(negedge MCLK);
        c1 = 1'b1;
        tick();
        check("resume_ack", bus.wr_ack, 1);
        bus.wr_req = 1'b0;
        exp_pms[0] = 3'd5;
        tick();
        check("resume_ack_end", bus.wr_ack, 0);
        sweep(24);

        // Write to ch1 on the tick that makes slot 1 current.
        guard = 0;
        while (exp_slot != 0 && guard < 30) begin
            tick();
            guard++;
        end
        check("align_slot0", slot, 0);
        @(negedge MCLK);
        bus.wr_req  = 1'b1;
        bus.wr_addr = {1'b0, 8'hB5};
        bus.wr_data = 8'h18;
        tick();
        check("bypass_ack", bus.wr_ack, 1);
        check("bypass_slot", slot, 1);
        check("bypass_pms", pms, 3);
        bus.wr_req = 1'b0;
        exp_pms[1] = 3'd3;
        sweep(24);

        // Reset asserted while a write is pending.
        @(negedge MCLK);
        bus.wr_req  = 1'b1;
        bus.wr_addr = {1'b0, 8'h22};
        bus.wr_data = 8'h0C;
        reset       = 1'b1;
        exp_slot    = 0;
        for (int i = 0; i < 6; i++) begin
            exp_pms[i]  = '0;
            exp_fnum[i] = '0;
        end
        repeat (3) begin
            tick();
            check("rstw_ack", bus.wr_ack, 0);
            check("rstw_lfo", lfo, 0);
            check("rstw_r21", reg_21, 0);
            check("rstw_slot", slot, 0);
            check("rstw_pms", pms, 0);
            check("rstw_fnum", fnum, 0);
        end
        @(negedge MCLK);
        reset = 1'b0;
        tick();
        check("post_rst_ack", bus.wr_ack, 1);
        check("post_rst_lfo", lfo, 4'hC);
        check("post_rst_slot", slot, exp_slot);
        bus.wr_req = 1'b0;
        sweep(24);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
